// File: rtl/alu_seq_param.sv
// Byte-serial ALU: operands A and B are loaded one byte per wr strobe, the
// result is computed in one EXEC cycle and then read out one byte per rd strobe.
module alu_seq_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned NBYTE = 2 * BYTES;
  localparam int unsigned CW    = $clog2(NBYTE);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EXEC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic             res_carry_q;
  logic             res_zero_q;
  logic [7:0]       uo_q;
  logic             valid_q;
  logic             carry_q;
  logic             zero_q;

  logic wr_c;
  logic rd_c;
  logic unused_ok;

  assign wr_c      = uio_in[0];
  assign rd_c      = uio_in[1];
  assign unused_ok = ^uio_in[7:5];

  // Arithmetic core, evaluated on the latched operands and op.
  logic [WIDTH:0]     sum_c;
  logic [WIDTH:0]     diff_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   res_c;
  logic               carry_c;

  assign sum_c  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_c = {1'b0, a_q} - {1'b0, b_q};
  assign prod_c = {WIDTH'(0), a_q} * {WIDTH'(0), b_q};

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    case (op_q)
      3'b000: {carry_c, res_c} = sum_c;
      3'b001: {carry_c, res_c} = diff_c;
      3'b010: res_c = a_q & b_q;
      3'b011: res_c = a_q | b_q;
      3'b100: res_c = a_q ^ b_q;
      3'b101: begin
        res_c   = a_q << 1;
        carry_c = a_q[WIDTH-1];
      end
      3'b110: begin
        res_c   = a_q >> 1;
        carry_c = a_q[0];
      end
      default: begin
        res_c   = prod_c[WIDTH-1:0];
        carry_c = |prod_c[2*WIDTH-1:WIDTH];
      end
    endcase
  end

  // Result byte to present next: a rd advances the index in the same cycle.
  logic [CW-1:0] out_idx_c;
  logic [7:0]    out_byte_c;

  assign out_idx_c = rd_c ? cnt_q + CW'(1) : cnt_q;

  always_comb begin
    out_byte_c = '0;
    for (int i = 0; i < int'(BYTES); i++) begin
      if (out_idx_c == CW'(i)) out_byte_c = res_q[i*8 +: 8];
    end
  end

  // Sequencer, operand/result storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 3'b000;
      res_q       <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      uo_q        <= '0;
      valid_q     <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else if (ena) begin
      case (state_q)
        LOAD: begin
          uo_q    <= '0;
          valid_q <= 1'b0;
          carry_q <= 1'b0;
          zero_q  <= 1'b0;
          if (wr_c) begin
            for (int i = 0; i < int'(BYTES); i++) begin
              if (cnt_q == CW'(i))         a_q[i*8 +: 8] <= ui_in;
              if (cnt_q == CW'(i + BYTES)) b_q[i*8 +: 8] <= ui_in;
            end
            if (cnt_q == CW'(NBYTE - 1)) begin
              op_q    <= uio_in[4:2];
              cnt_q   <= '0;
              state_q <= EXEC;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        EXEC: begin
          res_q       <= res_c;
          res_carry_q <= carry_c;
          res_zero_q  <= (res_c == '0);
          state_q     <= OUT;
        end

        OUT: begin
          if (wr_c) begin
            a_q[7:0] <= ui_in;
            cnt_q    <= CW'(1);
            state_q  <= LOAD;
            uo_q     <= '0;
            valid_q  <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
          end else if (rd_c && cnt_q == CW'(BYTES - 1)) begin
            cnt_q   <= '0;
            state_q <= LOAD;
            uo_q    <= '0;
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
          end else begin
            cnt_q   <= out_idx_c;
            uo_q    <= out_byte_c;
            valid_q <= 1'b1;
            carry_q <= res_carry_q;
            zero_q  <= res_zero_q;
          end
        end

        default: begin
          state_q <= LOAD;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {zero_q, carry_q, valid_q, 5'b00000};
  assign uio_oe  = 8'hE0;

endmodule
